avalon_bram_burst: RTL and testbench
====================================

// Module: avalon_bram_burst
// PURPOSE
//   Avalon-MM agent wrapping a byte-addressed block RAM. Successor of the single-word BRAM agent:
//   parametrised data width, per-byte write enables, pipelined read and write bursts.
//   Sits behind the Avalon interconnect as a scratch/frame memory for hosts and DMA engines.
// PARAMETERS
//   RAM_ADD_W     8   byte-address width; memory holds 2**RAM_ADD_W bytes
//   DATA_W        32  data width in bits (8,16,32,64); NB = DATA_W/8 byte lanes, WORDS = 2**RAM_ADD_W/NB
//   BURSTCOUNT_W  4   burstcount width; max burst MAXB = 2**(BURSTCOUNT_W-1) beats
// PORTS
//   clk            in   1              single clock, all logic on rising edge
//   reset_n        in   1              asynchronous, active-low reset
//   address        in   RAM_ADD_W      byte address; low log2(NB) bits ignored (word aligned)
//   read           in   1              read request
//   write          in   1              write request / write-burst beat
//   writedata      in   DATA_W         write data
//   byteenable     in   NB             per-lane write enable; ignored for reads
//   burstcount     in   BURSTCOUNT_W   beats in burst, sampled on first beat only
//   readdata       out  DATA_W         read data, valid when readdatavalid=1
//   readdatavalid  out  1              one pulse per read beat
//   waitrequest    out  1              1 = command not accepted this cycle
// BEHAVIOUR
//   - Reset (reset_n=0): waitrequest=1, readdatavalid=0, readdata=0, state IDLE, counters 0,
//     in-flight beats dropped; RAM contents NOT cleared. First cycle after release: waitrequest=0.
//   - Word index W = address[RAM_ADD_W-1:log2(NB)]; each beat advances W by 1, wrapping WORDS-1 -> 0.
//   - burstcount=0 treated as 1; burstcount>MAXB clamped to MAXB.
//   - Command accepted when (read|write) & !waitrequest. read&write together: write wins, read dropped.
//   - FSM:
//     IDLE: waitrequest=0. Accepted write -> store beat; if count>1 -> WR_BURST (remaining=count-1).
//           Accepted read -> RD_BURST (remaining=count, ptr=W).
//     RD_BURST: waitrequest=1; one RAM read per cycle, ptr++; after last RAM read -> IDLE.
//     WR_BURST: waitrequest=0; each cycle with write=1 stores one beat at next word (address ignored),
//           remaining--; write=0 cycles are stalls; remaining reaches 0 -> IDLE. read here ignored.
//   - Write: only lanes with byteenable[i]=1 update byte i; byteenable=0 beat counts but writes nothing.
//   - Read latency L (accept edge -> first readdatavalid): L=1 without output register, L=2 with.
//     Beats of one burst returned on consecutive cycles, in order, no gaps.
//   - Back-to-back: next read may be accepted the cycle after leaving RD_BURST while last beat of
//     previous burst is still in the output pipeline; ordering preserved.
//   - Read-during-write same word (different bursts): read returns the newly written data.
// CONFIGURATION
//   AVALON_BRAM_OUTREG_EN defined: extra register on readdata/readdatavalid, L=2, better Fmax.
//   Not defined: readdata driven straight from the RAM output register, L=1. Protocol otherwise identical.
// TESTING
//   - Reset: hold reset_n=0 mid RD_BURST of 4 -> readdatavalid=0 immediately, waitrequest=1; release ->
//     waitrequest=0 next cycle, no stray beats.
//   - Single write 0xDEADBEEF @0x10 be=4'b1111, read @0x10 burstcount=1 -> one beat 0xDEADBEEF at
//     accept+L.
//   - Byte enables: write 0x11223344 @0x20, then 0xAABBCCDD be=4'b0101 -> read 0x11BB33DD.
//   - Write burst 8 (MAXB) @0x00 data 0..7 with stalls after beats 2 and 5, read burst 8 -> 0..7 on 8
//     consecutive readdatavalid cycles, waitrequest=1 during RD_BURST.
//   - Wrap: RAM_ADD_W=8, DATA_W=32: write burst 4 @0xF8 data A,B,C,D -> words 62,63,0,1 hold A,B,C,D.
//   - Simultaneous read=write=1 in IDLE: write stored, no readdatavalid; run with and without
//     AVALON_BRAM_OUTREG_EN, check L=2 and L=1.

Source files
------------

// File: rtl/avalon_bram_burst_if.sv
// Avalon-MM bus bundle for avalon_bram_burst: master drives commands, slave returns read data.
// Handshake: a command is taken on a rising edge where (read|write)=1 and waitrequest=0; each
// readdatavalid=1 cycle carries exactly one read beat, and there is no backpressure on read data.
interface avalon_bram_burst_if #(
   parameter int RAM_ADD_W    = 8,
   parameter int DATA_W       = 32,
   parameter int BURSTCOUNT_W = 4
) ();
   logic [RAM_ADD_W-1:0]    address;
   logic                    read;
   logic                    write;
   logic [DATA_W-1:0]       writedata;
   logic [DATA_W/8-1:0]     byteenable;
   logic [BURSTCOUNT_W-1:0] burstcount;
   logic [DATA_W-1:0]       readdata;
   logic                    readdatavalid;
   logic                    waitrequest;

   modport master (
      output address, read, write, writedata, byteenable, burstcount,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable, burstcount,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/avalon_bram_burst.sv
// Avalon-MM burst agent in front of a byte-enabled block RAM with wrapping word pointer.
// Define AVALON_BRAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module avalon_bram_burst #(
   parameter int RAM_ADD_W    = 8,
   parameter int DATA_W       = 32,
   parameter int BURSTCOUNT_W = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   avalon_bram_burst_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int NB    = DATA_W / 8;
   localparam int LB    = $clog2(NB);
   localparam int WI_W  = RAM_ADD_W - LB;
   localparam int WORDS = 2 ** WI_W;
   localparam int MAXB  = 2 ** (BURSTCOUNT_W - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic                    run;
   logic [BURSTCOUNT_W-1:0] remaining, remaining_nxt;
   logic [WI_W-1:0]         ptr, ptr_nxt;
   logic [WI_W-1:0]         cmd_word;
   logic [BURSTCOUNT_W-1:0] cmd_count;
   logic                    wr_en;
   logic [WI_W-1:0]         wr_word;
   logic                    rd_en;
   logic [DATA_W-1:0]       mem [WORDS];
   logic [DATA_W-1:0]       ram_q;
   logic                    ram_v;
   logic                    unused_addr_bits;

   assign cmd_word         = bus.address[RAM_ADD_W-1:LB];
   assign unused_addr_bits = ^bus.address;
   assign dbg_state        = state;

   always_comb begin
      cmd_count = bus.burstcount;
      if (bus.burstcount == '0)
         cmd_count = BURSTCOUNT_W'(1);
      else if (bus.burstcount > BURSTCOUNT_W'(MAXB))
         cmd_count = BURSTCOUNT_W'(MAXB);
   end

   // run stays low until the first edge after reset release so waitrequest covers reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         run       <= 1'b0;
         remaining <= '0;
         ptr       <= '0;
      end else begin
         state     <= state_nxt;
         run       <= 1'b1;
         remaining <= remaining_nxt;
         ptr       <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      remaining_nxt   = remaining;
      ptr_nxt         = ptr;
      wr_en           = 1'b0;
      wr_word         = ptr;
      rd_en           = 1'b0;
      bus.waitrequest = !run;
      case (state)
         IDLE: begin
            if (run) begin
               if (bus.write) begin
                  wr_en   = 1'b1;
                  wr_word = cmd_word;
                  ptr_nxt = cmd_word + WI_W'(1);
                  if (cmd_count > BURSTCOUNT_W'(1)) begin
                     remaining_nxt = cmd_count - BURSTCOUNT_W'(1);
                     state_nxt     = WR_BURST;
                  end
               end else if (bus.read) begin
                  ptr_nxt       = cmd_word;
                  remaining_nxt = cmd_count;
                  state_nxt     = RD_BURST;
               end
            end
         end
         RD_BURST: begin
            bus.waitrequest = 1'b1;
            rd_en           = 1'b1;
            ptr_nxt         = ptr + WI_W'(1);
            remaining_nxt   = remaining - BURSTCOUNT_W'(1);
            if (remaining == BURSTCOUNT_W'(1))
               state_nxt = IDLE;
         end
         WR_BURST: begin
            if (bus.write) begin
               wr_en         = 1'b1;
               ptr_nxt       = ptr + WI_W'(1);
               remaining_nxt = remaining - BURSTCOUNT_W'(1);
               if (remaining == BURSTCOUNT_W'(1))
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM array is never reset; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.byteenable[i])
               mem[wr_word][i*8 +: 8] <= bus.writedata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_q <= '0;
         ram_v <= 1'b0;
      end else begin
         ram_v <= rd_en;
         if (rd_en)
            ram_q <= mem[ptr];
      end
   end

`ifdef AVALON_BRAM_OUTREG_EN
   logic [DATA_W-1:0] out_q;
   logic              out_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
         out_v <= 1'b0;
      end else begin
         out_q <= ram_q;
         out_v <= ram_v;
      end
   end

   assign bus.readdata      = out_q;
   assign bus.readdatavalid = out_v;
`else
   assign bus.readdata      = ram_q;
   assign bus.readdatavalid = ram_v;
`endif
endmodule

// File: tb/tb_avalon_bram_burst.sv
// Self-checking bench for avalon_bram_burst: byte-array reference model, expected-beat queue
// scoreboard with per-beat cycle checks, directed scenarios plus randomized back-to-back traffic.
module tb_avalon_bram_burst;
`ifdef AVALON_BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       reset_n;
   logic [1:0] dbg_state;
   int         cyc;
   int         checks;
   int         errors;
   int         rv_count;
   int         acc_cyc;

   logic [7:0]  mem_m [256];
   logic [31:0] wd [8];
   logic [3:0]  be_a [8];
   logic [31:0] exp_q [$];
   int          exp_cyc_q [$];

   avalon_bram_burst_if bus ();

   avalon_bram_burst dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic int eff_count(input logic [3:0] bc);
      if (bc == 4'd0) return 1;
      if (bc > 4'd8) return 8;
      return int'(bc);
   endfunction

   function automatic logic [31:0] model_word(input int w);
      int base;
      base = (w % 64) * 4;
      return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
   endfunction

   function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] be);
      int base;
      base = (w % 64) * 4;
      for (int i = 0; i < 4; i++)
         if (be[i]) mem_m[base+i] = d[i*8 +: 8];
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [31:0] ed;
      int          ec;
      if (bus.readdatavalid === 1'b1) begin
         rv_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stray_beat: readdata=%h at cycle %0d, no beat expected", bus.readdata, cyc);
         end else begin
            ed = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (bus.readdata !== ed) begin
               errors++;
               $display("FAIL read_data: got %h expected %h at cycle %0d", bus.readdata, ed, cyc);
            end
            checks++;
            if (cyc !== ec) begin
               errors++;
               $display("FAIL read_timing: beat at cycle %0d expected cycle %0d", cyc, ec);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_idle();
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;
      bus.byteenable = '0;
      bus.burstcount = '0;
   endtask

   // Called at a negedge with a command driven; returns at the negedge after the accept edge.
   task automatic wait_accept();
      int guard;
      guard = 0;
      while (bus.waitrequest !== 1'b0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: waitrequest=%b after %0d cycles, expected 0", bus.waitrequest, guard);
      end
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic write_burst(input logic [7:0] addr, input logic [3:0] bc,
                              input int stall_a, input int stall_b, input logic also_read);
      int n;
      n = eff_count(bc);
      for (int i = 0; i < n; i++) begin
         bus.write      = 1'b1;
         bus.writedata  = wd[i];
         bus.byteenable = be_a[i];
         bus.address    = (i == 0) ? addr : 8'($urandom);
         bus.burstcount = (i == 0) ? bc : 4'($urandom);
         bus.read       = (i == 0) ? also_read : 1'($urandom_range(0, 1));
         wait_accept();
         model_write(int'(addr[7:2]) + i, wd[i], be_a[i]);
         bus.write = 1'b0;
         bus.read  = 1'b0;
         if (i == stall_a || i == stall_b) @(negedge clk);
      end
   endtask

   task automatic read_burst(input logic [7:0] addr, input logic [3:0] bc);
      int n;
      n = eff_count(bc);
      bus.read       = 1'b1;
      bus.write      = 1'b0;
      bus.address    = addr;
      bus.burstcount = bc;
      bus.byteenable = 4'($urandom);
      wait_accept();
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(model_word(int'(addr[7:2]) + i));
         exp_cyc_q.push_back(acc_cyc + LAT + i);
      end
      bus.read = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus_idle();
      reset_n = 1'b0;
      #3;
      checks++;
      if (bus.waitrequest !== 1'b1) begin
         errors++; $display("FAIL reset_waitrequest: got %b expected 1", bus.waitrequest);
      end
      checks++;
      if (bus.readdatavalid !== 1'b0) begin
         errors++; $display("FAIL reset_readdatavalid: got %b expected 0", bus.readdatavalid);
      end
      checks++;
      if (bus.readdata !== 32'h0) begin
         errors++; $display("FAIL reset_readdata: got %h expected 0", bus.readdata);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1 checks++;
      if (bus.waitrequest !== 1'b0) begin
         errors++; $display("FAIL release_waitrequest: got %b expected 0", bus.waitrequest);
      end
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 8; i++) begin
            wd[i]   = $urandom;
            be_a[i] = 4'hF;
         end
         write_burst(8'(b * 32), 4'd8, -1, -1, 1'b0);
      end
      for (int b = 0; b < 8; b++) read_burst(8'(b * 32), 4'd8);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL fill_beats_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_single();
      wd[0] = 32'hDEADBEEF; be_a[0] = 4'hF;
      write_burst(8'h10, 4'd1, -1, -1, 1'b0);
      read_burst(8'h10, 4'd1);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL single_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_byteenable();
      wd[0] = 32'h11223344; be_a[0] = 4'hF;
      write_burst(8'h20, 4'd1, -1, -1, 1'b0);
      wd[0] = 32'hAABBCCDD; be_a[0] = 4'b0101;
      write_burst(8'h20, 4'd1, -1, -1, 1'b0);
      read_burst(8'h20, 4'd1);
      wd[0] = 32'hFFFFFFFF; be_a[0] = 4'b0000;
      write_burst(8'h24, 4'd1, -1, -1, 1'b0);
      read_burst(8'h24, 4'd1);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL byteenable_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_burst_stalls();
      for (int i = 0; i < 8; i++) begin
         wd[i] = 32'(i); be_a[i] = 4'hF;
      end
      write_burst(8'h00, 4'd8, 1, 4, 1'b0);
      read_burst(8'h00, 4'd8);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.waitrequest !== 1'b1) begin
            errors++; $display("FAIL rd_burst_waitrequest: got %b expected 1 at beat %0d", bus.waitrequest, k);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.waitrequest !== 1'b0) begin
         errors++; $display("FAIL rd_burst_end_waitrequest: got %b expected 0", bus.waitrequest);
      end
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL burst_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_wrap();
      wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003; wd[3] = 32'hDDDD0004;
      for (int i = 0; i < 4; i++) be_a[i] = 4'hF;
      write_burst(8'hF8, 4'd4, -1, -1, 1'b0);
      read_burst(8'hF8, 4'd4);
      read_burst(8'h00, 4'd2);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL wrap_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_read_write_same();
      int rv_before;
      wd[0] = $urandom; be_a[0] = 4'hF;
      rv_before = rv_count;
      write_burst(8'h44, 4'd1, -1, -1, 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (rv_count !== rv_before) begin
         errors++; $display("FAIL rw_same_readdatavalid: %0d beats expected 0", rv_count - rv_before);
      end
      read_burst(8'h44, 4'd1);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL rw_same_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_burst_limits();
      int rv_before;
      wd[0] = $urandom; be_a[0] = 4'hF;
      wd[1] = $urandom; be_a[1] = 4'hF;
      write_burst(8'h60, 4'd0, -1, -1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         wd[i] = $urandom; be_a[i] = 4'($urandom);
      end
      write_burst(8'h80, 4'd15, -1, -1, 1'b0);
      rv_before = rv_count;
      read_burst(8'h60, 4'd0);
      read_burst(8'h80, 4'd15);
      drain();
      checks++;
      if (rv_count - rv_before !== 9) begin
         errors++; $display("FAIL burst_limits_beats: got %0d expected 9", rv_count - rv_before);
      end
   endtask

   task automatic test_reset_mid_burst();
      int rv_before;
      read_burst(8'hC0, 4'd4);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      exp_cyc_q.delete();
      checks++;
      if (bus.readdatavalid !== 1'b0) begin
         errors++; $display("FAIL midreset_readdatavalid: got %b expected 0", bus.readdatavalid);
      end
      checks++;
      if (bus.waitrequest !== 1'b1) begin
         errors++; $display("FAIL midreset_waitrequest: got %b expected 1", bus.waitrequest);
      end
      rv_before = rv_count;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1 checks++;
      if (bus.waitrequest !== 1'b0) begin
         errors++; $display("FAIL midreset_release_waitrequest: got %b expected 0", bus.waitrequest);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (rv_count !== rv_before) begin
         errors++; $display("FAIL midreset_stray_beats: %0d beats expected 0", rv_count - rv_before);
      end
      read_burst(8'hC0, 4'd4);
      drain();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL midreset_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int rv_before;
      int exp_beats;
      rv_before = rv_count;
      exp_beats = 0;
      for (int k = 0; k < 40; k++) begin
         logic [7:0] a;
         logic [3:0] bc;
         a  = 8'($urandom);
         bc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) != 0) begin
            read_burst(a, bc);
            exp_beats += eff_count(bc);
         end else begin
            for (int i = 0; i < 8; i++) begin
               wd[i] = $urandom; be_a[i] = 4'($urandom);
            end
            write_burst(a, bc, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
         end
      end
      drain();
      checks++;
      if (rv_count - rv_before !== exp_beats) begin
         errors++; $display("FAIL b2b_beat_count: got %0d expected %0d", rv_count - rv_before, exp_beats);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL b2b_beat_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      rv_count = 0;
      for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
      test_reset();
      test_fill();
      test_single();
      test_byteenable();
      test_burst_stalls();
      test_wrap();
      test_read_write_same();
      test_burst_limits();
      test_reset_mid_burst();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
